// File: rtl/muldiv_pkg.sv
// Shared constants, FSM encoding and helpers for the iterative mul/div unit.
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int ITERS = 64;
  localparam int CNT_W = $clog2(ITERS);

  // Per-engine handshake FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide-by-zero quotient and the one signed input that overflows
  localparam logic [XLEN-1:0] QUOT_DIV0 = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // Magnitude of a value; unsigned operands pass straight through
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            sgn);
    return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_divider.sv
// Restoring radix-2 divider: works on magnitudes, fixes signs at the end.
// One quotient bit per clock, fixed ITERS-cycle latency including special cases.
module iter_divider
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_signed,
  output logic            o_ready,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  state_t             r_state;
  logic               r_ready;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]    r_q;        // dividend magnitude shifting out, quotient shifting in
  logic [XLEN-1:0]    r_r;        // partial remainder, always < r_d
  logic [XLEN-1:0]    r_d;        // divisor magnitude
  logic [XLEN-1:0]    r_a_orig;   // original dividend, returned as remainder on /0
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;
  logic               r_ovf;
  logic [XLEN-1:0]    r_quot;
  logic [XLEN-1:0]    r_rem;

  logic [XLEN:0]      w_shift;
  logic               w_ge;
  logic [XLEN-1:0]    w_r_next;
  logic [XLEN-1:0]    w_q_next;
  logic [XLEN-1:0]    w_quot_fin;
  logic [XLEN-1:0]    w_rem_fin;
  logic               w_last;

  // One restoring step plus the sign/special-case fix-up of the final step
  always_comb begin
    w_shift  = {r_r, r_q[XLEN-1]};
    w_ge     = (w_shift >= {1'b0, r_d});
    // Partial remainder stays below the divisor, so the difference fits in XLEN bits
    w_r_next = w_ge ? (w_shift[XLEN-1:0] - r_d) : w_shift[XLEN-1:0];
    w_q_next = {r_q[XLEN-2:0], w_ge};
    w_last   = (r_cnt == CNT_W'(ITERS - 1));
    if (r_div_zero) begin
      w_quot_fin = QUOT_DIV0;
      w_rem_fin  = r_a_orig;
    end else if (r_ovf) begin
      w_quot_fin = INT_MIN;
      w_rem_fin  = '0;
    end else begin
      w_quot_fin = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
      w_rem_fin  = r_neg_r ? (~w_r_next + 1'b1) : w_r_next;
    end
  end

  // Divider FSM with registered handshake outputs and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_a_orig    <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
    end else if (flush) begin
      // Abort silently; results from earlier operations are kept
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (i_valid) begin
            r_state    <= ST_BUSY;
            r_ready    <= 1'b0;
            r_cnt      <= '0;
            r_q        <= abs_val(i_a, i_signed);
            r_d        <= abs_val(i_b, i_signed);
            r_r        <= '0;
            r_a_orig   <= i_a;
            r_neg_q    <= i_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_r    <= i_signed & i_a[XLEN-1];
            r_div_zero <= (i_b == '0);
            r_ovf      <= i_signed && (i_a == INT_MIN) && (i_b == QUOT_DIV0);
          end
        end
        ST_BUSY: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_quot      <= w_quot_fin;
            r_rem       <= w_rem_fin;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_out_valid = r_out_valid;
  assign o_quot      = r_quot;
  assign o_rem       = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64 multiply/divide unit: independent shift-add multiplier
// (low 64 bits of product) and restoring divider, each with its own handshake.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mul_valid,
  input  logic [XLEN-1:0] mul_a,
  input  logic [XLEN-1:0] mul_b,
  output logic            mul_ready,
  output logic            mul_out_valid,
  output logic [XLEN-1:0] mul_res,
  input  logic            div_valid,
  input  logic [XLEN-1:0] div_a,
  input  logic [XLEN-1:0] div_b,
  input  logic            div_signed,
  output logic            div_ready,
  output logic            div_out_valid,
  output logic [XLEN-1:0] div_quot,
  output logic [XLEN-1:0] div_rem
);

  state_t             r_mul_state;
  logic               r_mul_ready;
  logic               r_mul_out_valid;
  logic [CNT_W-1:0]   r_mul_cnt;
  logic [XLEN-1:0]    r_mul_a;     // multiplicand, shifted left each step
  logic [XLEN-1:0]    r_mul_b;     // multiplier, shifted right each step
  logic [XLEN-1:0]    r_mul_acc;
  logic [XLEN-1:0]    r_mul_res;
  logic [XLEN-1:0]    w_mul_acc_next;

  // Shift-add step: bits above XLEN never reach the low half, so they are dropped
  always_comb begin
    w_mul_acc_next = r_mul_b[0] ? (r_mul_acc + r_mul_a) : r_mul_acc;
  end

  // Multiplier FSM with registered handshake outputs and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mul_state     <= ST_IDLE;
      r_mul_ready     <= 1'b1;
      r_mul_out_valid <= 1'b0;
      r_mul_cnt       <= '0;
      r_mul_a         <= '0;
      r_mul_b         <= '0;
      r_mul_acc       <= '0;
      r_mul_res       <= '0;
    end else if (flush) begin
      r_mul_state     <= ST_IDLE;
      r_mul_ready     <= 1'b1;
      r_mul_out_valid <= 1'b0;
    end else begin
      case (r_mul_state)
        ST_IDLE: begin
          r_mul_out_valid <= 1'b0;
          if (mul_valid) begin
            r_mul_state <= ST_BUSY;
            r_mul_ready <= 1'b0;
            r_mul_cnt   <= '0;
            r_mul_a     <= mul_a;
            r_mul_b     <= mul_b;
            r_mul_acc   <= '0;
          end
        end
        ST_BUSY: begin
          r_mul_acc <= w_mul_acc_next;
          r_mul_a   <= {r_mul_a[XLEN-2:0], 1'b0};
          r_mul_b   <= {1'b0, r_mul_b[XLEN-1:1]};
          r_mul_cnt <= r_mul_cnt + 1'b1;
          if (r_mul_cnt == CNT_W'(ITERS - 1)) begin
            r_mul_state     <= ST_DONE;
            r_mul_out_valid <= 1'b1;
            r_mul_res       <= w_mul_acc_next;
          end
        end
        ST_DONE: begin
          r_mul_state     <= ST_IDLE;
          r_mul_ready     <= 1'b1;
          r_mul_out_valid <= 1'b0;
        end
        default: begin
          r_mul_state     <= ST_IDLE;
          r_mul_ready     <= 1'b1;
          r_mul_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mul_ready     = r_mul_ready;
  assign mul_out_valid = r_mul_out_valid;
  assign mul_res       = r_mul_res;

  iter_divider u_div (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .i_valid     (div_valid),
    .i_a         (div_a),
    .i_b         (div_b),
    .i_signed    (div_signed),
    .o_ready     (div_ready),
    .o_out_valid (div_out_valid),
    .o_quot      (div_quot),
    .o_rem       (div_rem)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operands against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mul_valid;
  logic [63:0] mul_a, mul_b;
  logic        mul_ready, mul_out_valid;
  logic [63:0] mul_res;
  logic        div_valid;
  logic [63:0] div_a, div_b;
  logic        div_signed;
  logic        div_ready, div_out_valid;
  logic [63:0] div_quot, div_rem;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mul_valid     (mul_valid),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_ready     (mul_ready),
    .mul_out_valid (mul_out_valid),
    .mul_res       (mul_res),
    .div_valid     (div_valid),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_signed    (div_signed),
    .div_ready     (div_ready),
    .div_out_valid (div_out_valid),
    .div_quot      (div_quot),
    .div_rem       (div_rem)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference model straight from the arithmetic rules
  function automatic void model_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                                    output logic [63:0] q, output logic [63:0] r);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a;
      r = 64'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Launch one or both engines the same cycle and watch 80 cycles of outputs
  task automatic run_op(input string tag, input bit do_mul, input bit do_div,
                        input logic [63:0] ma, input logic [63:0] mb,
                        input logic [63:0] da, input logic [63:0] db, input logic ds);
    logic [63:0] exp_m, exp_q, exp_r, prev_m, prev_q, prev_r;
    logic [63:0] got_m, got_q, got_r;
    int m_pulses, d_pulses, m_cyc, d_cyc;
    exp_m = ma * mb;
    model_div(da, db, ds, exp_q, exp_r);
    prev_m = mul_res;
    prev_q = div_quot;
    prev_r = div_rem;
    m_pulses = 0; d_pulses = 0; m_cyc = -1; d_cyc = -1;
    got_m = '0; got_q = '0; got_r = '0;
    @(negedge clk);
    mul_valid = do_mul; mul_a = ma; mul_b = mb;
    div_valid = do_div; div_a = da; div_b = db; div_signed = ds;
    @(negedge clk);
    // Scramble inputs after accept; engines must have latched them already
    mul_valid = 1'b0; div_valid = 1'b0;
    mul_a = rnd64(); mul_b = rnd64(); div_a = rnd64(); div_b = rnd64();
    div_signed = ~ds;
    check({tag, "_mrdy"}, {63'd0, mul_ready}, {63'd0, ~do_mul});
    check({tag, "_drdy"}, {63'd0, div_ready}, {63'd0, ~do_div});
    for (int k = 0; k < 80; k++) begin
      if (mul_out_valid) begin
        m_pulses++;
        m_cyc = k;
        got_m = mul_res;
      end
      if (div_out_valid) begin
        d_pulses++;
        d_cyc = k;
        got_q = div_quot;
        got_r = div_rem;
      end
      @(negedge clk);
    end
    if (do_mul) begin
      check({tag, "_mpulses"}, 64'(m_pulses), 64'd1);
      check({tag, "_mlat"}, 64'(m_cyc), 64'd64);
      check({tag, "_mres"}, got_m, exp_m);
      check({tag, "_mhold"}, mul_res, exp_m);
    end else begin
      check({tag, "_mpulses"}, 64'(m_pulses), 64'd0);
      check({tag, "_mhold"}, mul_res, prev_m);
    end
    if (do_div) begin
      check({tag, "_dpulses"}, 64'(d_pulses), 64'd1);
      check({tag, "_dlat"}, 64'(d_cyc), 64'd64);
      check({tag, "_quot"}, got_q, exp_q);
      check({tag, "_rem"}, got_r, exp_r);
      check({tag, "_rhold"}, div_rem, exp_r);
    end else begin
      check({tag, "_dpulses"}, 64'(d_pulses), 64'd0);
      check({tag, "_qhold"}, div_quot, prev_q);
      check({tag, "_rhold"}, div_rem, prev_r);
    end
    $display("op %s mul=%0b %h*%h div=%0b s=%0b %h/%h -> res=%h q=%h r=%h",
             tag, do_mul, ma, mb, do_div, ds, da, db, got_m, got_q, got_r);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mrdy"}, {63'd0, mul_ready}, 64'd1);
    check({tag, "_drdy"}, {63'd0, div_ready}, 64'd1);
    check({tag, "_mov"}, {63'd0, mul_out_valid}, 64'd0);
    check({tag, "_dov"}, {63'd0, div_out_valid}, 64'd0);
    check({tag, "_mres"}, mul_res, 64'd0);
    check({tag, "_quot"}, div_quot, 64'd0);
    check({tag, "_rem"}, div_rem, 64'd0);
  endtask

  initial begin
    logic [63:0] q_before, r_before, ra, rb;
    int pulses;
    rst = 1'b0; flush = 1'b0;
    mul_valid = 1'b0; mul_a = '0; mul_b = '0;
    div_valid = 1'b0; div_a = '0; div_b = '0; div_signed = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // Directed cases
    run_op("mul3x5",  1, 0, 64'd3, 64'd5, 64'd0, 64'd0, 1'b0);
    run_op("mulFFx2", 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 1'b0);
    run_op("divu100_7", 0, 1, 64'd0, 64'd0, 64'd100, 64'd7, 1'b0);
    run_op("divu5_0",   0, 1, 64'd0, 64'd0, 64'd5, 64'd0, 1'b0);
    run_op("divs-7_2",  0, 1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    run_op("divs_ovf",  0, 1, 64'd0, 64'd0, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("divs-5_0",  0, 1, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1);
    run_op("both",      1, 1, 64'd123456789, 64'd987654321, 64'd1000, 64'd33, 1'b0);

    // Flush abort 10 cycles into a divide
    q_before = div_quot;
    r_before = div_rem;
    @(negedge clk);
    div_valid = 1'b1; div_a = 64'd1000; div_b = 64'd7; div_signed = 1'b0;
    @(negedge clk);
    div_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    div_valid = 1'b1;  // must not be accepted together with flush
    @(negedge clk);
    flush = 1'b0;
    div_valid = 1'b0;
    check("flush_drdy", {63'd0, div_ready}, 64'd1);
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      if (div_out_valid) pulses++;
      @(negedge clk);
    end
    check("flush_pulses", 64'(pulses), 64'd0);
    check("flush_qhold", div_quot, q_before);
    check("flush_rhold", div_rem, r_before);
    $display("op flush abort: pulses=%0d", pulses);
    run_op("div9_3", 0, 1, 64'd0, 64'd0, 64'd9, 64'd3, 1'b0);

    // Randomized operands, both engines concurrently
    for (int i = 0; i < 30; i++) begin
      ra = rnd64();
      rb = rnd64();
      case ($urandom_range(0, 4))
        0: rb = 64'($urandom_range(0, 20));
        1: rb = {{32{rb[31]}}, rb[31:0]};
        2: ra = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), 1, 1, rnd64(), rnd64(), ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation
    @(negedge clk);
    mul_valid = 1'b1; mul_a = 64'd77; mul_b = 64'd11;
    div_valid = 1'b1; div_a = 64'd500; div_b = 64'd9; div_signed = 1'b0;
    @(negedge clk);
    mul_valid = 1'b0; div_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset_values("midrst");
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      if (mul_out_valid || div_out_valid) pulses++;
      @(negedge clk);
    end
    check("midrst_pulses", 64'(pulses), 64'd0);
    $display("op reset mid-operation: pulses=%0d", pulses);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
